// File: rtl/serial_rx_deframer.sv
// serial_rx_deframer: recovers start/8N/stop frames from an asynchronous line into bytes.
// Define RX_MAJORITY_VOTE_EN to decide each bit by a 2-of-3 vote around mid-bit.
module serial_rx_deframer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int CNT_W        = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serialIn,
    output logic [7:0] dataOut,
    output logic       valid,
    output logic       frameErr,
    output logic       busy
);
    localparam int H = CLKS_PER_BIT / 2;
`ifdef RX_MAJORITY_VOTE_EN
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(H + 1);
`else
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(H);
`endif
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t           state_q, state_d;
    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       sh_q, sh_d, data_q, data_d;
    logic             valid_q, valid_d, ferr_q, ferr_d;
    logic             rx_s, bit_s, at_sample;

    assign rx_s = sync_q[1];
    assign sync_d = {sync_q[0], serialIn};

`ifdef RX_MAJORITY_VOTE_EN
    // Last two synchronized samples; the vote window ends at the decision cycle.
    logic [1:0] hist_q, hist_d;
    assign hist_d = {hist_q[0], rx_s};
    assign bit_s = (hist_q[0] & hist_q[1]) | (hist_q[0] & rx_s) | (hist_q[1] & rx_s);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) hist_q <= 2'b11;
        else      hist_q <= hist_d;
    end
`else
    assign bit_s = rx_s;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sh_d      = sh_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        at_sample = (state_q == START) ? (cnt_q == START_LAST) : (cnt_q == BIT_LAST);
        cnt_d     = at_sample ? '0 : cnt_q + CNT_W'(1);
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                idx_d = 3'd0;
                if (at_sample) state_d = bit_s ? IDLE : DATA;
            end
            DATA: begin
                if (at_sample) begin
                    sh_d  = {bit_s, sh_q[7:1]};
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (at_sample) begin
                    data_d  = bit_s ? sh_q : data_q;
                    valid_d = bit_s;
                    ferr_d  = !bit_s;
                    state_d = bit_s ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            sh_q    <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign dataOut  = data_q;
    assign valid    = valid_q;
    assign frameErr = ferr_q;
    assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_serial_rx_deframer.sv
// tb_serial_rx_deframer: frame-level reference model plus directed and random frames.
module tb_serial_rx_deframer;
    localparam int N = 8;
    localparam int H = N / 2;
`ifdef RX_MAJORITY_VOTE_EN
    localparam int OFF = 1;
    localparam int T1_LAT = 81;
    localparam logic [7:0] T6_DATA = 8'hFF;
`else
    localparam int OFF = 0;
    localparam int T1_LAT = 80;
    localparam logic [7:0] T6_DATA = 8'hFE;
`endif

    logic clk = 1'b0, rst = 1'b0, serialIn = 1'b1;
    logic [7:0] dataOut;
    logic valid, frameErr, busy;

    serial_rx_deframer #(.CLKS_PER_BIT(N), .CNT_W(10)) dut (
        .clk(clk), .rst(rst), .serialIn(serialIn),
        .dataOut(dataOut), .valid(valid), .frameErr(frameErr), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: line history plus the per-frame sampling schedule.
    bit ln [int];
    int last_rst = 0;
    int mph = 0;
    int ms = 0;
    logic [7:0] msh = 8'h00, mdata = 8'h00;
    bit pv = 0, pf = 0;
    int vcyc[$];
    logic [7:0] vdat[$];
    int ferr_cnt = 0;

    function automatic bit rxv(input int c);
        if (c - last_rst <= 2 || !ln.exists(c - 2)) return 1'b1;
        return ln[c - 2];
    endfunction

    function automatic bit samp(input int t);
        bit a, b, c;
        a = rxv(t - 2); b = rxv(t - 1); c = rxv(t);
        return (OFF == 1) ? ((a & b) | (a & c) | (b & c)) : c;
    endfunction

    task automatic step(input int t);
        bit nv, nf, b;
        int rel, j;
        nv = 0; nf = 0;
        if (mph == 0) begin
            if (!rxv(t)) begin mph = 1; ms = t + 1; end
        end else if (mph == 1) begin
            rel = t - (ms + H + OFF);
            if (rel >= 0 && rel % N == 0) begin
                j = rel / N;
                b = samp(t);
                if (j == 0 && b) mph = 0;
                else if (j >= 1 && j <= 8) msh[j-1] = b;
                else if (j == 9) begin
                    if (b) begin mdata = msh; nv = 1; mph = 0; end
                    else begin nf = 1; mph = 2; end
                end
            end
        end else if (rxv(t)) mph = 0;
        pv = nv; pf = nf;
    endtask

    always @(negedge clk) begin
        ln[cyc] = serialIn;
        if (!rst) begin
            mph = 0; mdata = 8'h00; pv = 0; pf = 0; last_rst = cyc;
        end
        chk("valid", 32'(valid), 32'(pv));
        chk("frameErr", 32'(frameErr), 32'(pf));
        chk("busy", 32'(busy), 32'(mph != 0));
        chk("dataOut", 32'(dataOut), 32'(mdata));
        if (valid) begin vcyc.push_back(cyc); vdat.push_back(dataOut); end
        if (frameErr) ferr_cnt++;
        if (rst) step(cyc);
    end

    task automatic put(input logic v, input int n);
        serialIn = v;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic frame(input logic [7:0] d, input logic stop, input int g);
        logic v;
        for (int c = 0; c < 10 * N; c++) begin
            v = (c / N == 0) ? 1'b0 : (c / N == 9) ? stop : d[c / N - 1];
            if (c == g) v = ~v;
            put(v, 1);
        end
    endtask

    function automatic int vat(input int i);
        return (vcyc.size() > i) ? vcyc[i] : -1;
    endfunction

    function automatic logic [7:0] vdt(input int i);
        return (vdat.size() > i) ? vdat[i] : 8'hxx;
    endfunction

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    int k0;
    logic [7:0] rb;
    logic bad;
    int g;
    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        put(1'b1, 20);
        chk("reset_data", 32'(dataOut), 32'h00);
        // 1: single good frame
        vcyc.delete(); vdat.delete(); ferr_cnt = 0; k0 = cyc;
        frame(8'hA5, 1'b1, -1); put(1'b1, 20);
        chk("t1_pulses", 32'(vcyc.size()), 32'd1);
        chk("t1_latency", 32'(vat(0) - k0), 32'(T1_LAT));
        chk("t1_data", 32'(vdt(0)), 32'hA5);
        chk("t1_ferr", 32'(ferr_cnt), 32'd0);
        // 2: short start glitch
        vcyc.delete(); ferr_cnt = 0;
        put(1'b0, 2); put(1'b1, 30);
        chk("t2_pulses", 32'(vcyc.size()), 32'd0);
        chk("t2_ferr", 32'(ferr_cnt), 32'd0);
        chk("t2_busy", 32'(busy), 32'd0);
        // 3: bad stop then stuck-low line
        vcyc.delete(); ferr_cnt = 0;
        frame(8'h3C, 1'b0, -1); put(1'b0, 40);
        chk("t3_wait_busy", 32'(busy), 32'd1);
        put(1'b1, 20);
        chk("t3_ferr", 32'(ferr_cnt), 32'd1);
        chk("t3_pulses", 32'(vcyc.size()), 32'd0);
        chk("t3_hold", 32'(dataOut), 32'hA5);
        frame(8'h5A, 1'b1, -1); put(1'b1, 20);
        chk("t3_next", 32'(dataOut), 32'h5A);
        // 4: back-to-back frames
        vcyc.delete(); vdat.delete();
        frame(8'h3C, 1'b1, -1); frame(8'hC3, 1'b1, -1); put(1'b1, 20);
        chk("t4_pulses", 32'(vcyc.size()), 32'd2);
        chk("t4_gap", 32'(vat(1) - vat(0)), 32'd80);
        chk("t4_d0", 32'(vdt(0)), 32'h3C);
        chk("t4_d1", 32'(vdt(1)), 32'hC3);
        // 5: reset during data bit 4
        vcyc.delete();
        put(1'b0, N); put(1'b1, 4 * N + 3);
        rst = 1'b0; #1;
        chk("t5_rst_data", 32'(dataOut), 32'h00);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        put(1'b1, 1);
        rst = 1'b1;
        put(1'b1, 4 * N);
        chk("t5_pulses", 32'(vcyc.size()), 32'd0);
        frame(8'h81, 1'b1, -1); put(1'b1, 20);
        chk("t5_next", 32'(dataOut), 32'h81);
        // 6: one-clock glitch at the single-sample point of data bit 0
        vcyc.delete(); vdat.delete(); k0 = cyc;
        frame(8'hFF, 1'b1, N + H + 1); put(1'b1, 20);
        chk("t6_data", 32'(vdt(0)), 32'(T6_DATA));
        chk("t6_latency", 32'(vat(0) - k0), 32'(T1_LAT));
        // 7: random traffic
        for (int i = 0; i < 40; i++) begin
            rb  = 8'($urandom);
            bad = ($urandom_range(0, 5) == 0);
            g   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10 * N - 1)) : -1;
            frame(rb, !bad, g);
            if (bad) begin
                put(1'b0, $urandom_range(0, 20));
                put(1'b1, $urandom_range(1, 10));
            end else put(1'b1, $urandom_range(0, 6));
        end
        put(1'b1, 30);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
